fetch_pair_unit: RTL and testbench
==================================

FETCH_PAIR_UNIT -- requirements
Module: fetch_pair_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset; SHALL be 8-byte aligned.
REQ-002 Parameter QDEPTH, default 4: instruction-pair queue depth; SHALL be a power of two, 2..8.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset: asserted when low, released synchronously to clk.
REQ-005 start  in  1  level; begins fetching from IDLE.
REQ-006 imem_req  out  1  memory read request this cycle.
REQ-007 imem_addr  out  32  8-aligned pair address.
REQ-008 imem_rdata  in  64  pair returned exactly one cycle after imem_req; [31:0]=word at addr, [63:32]=word at addr+4.
REQ-009 redirect  in  1  flush and restart fetch.
REQ-010 redirect_pc  in  32  new fetch address; 8-aligned, bits [2:0] SHALL be ignored.
REQ-011 valid  out  1  queue head holds a pair for the decoder.
REQ-012 ready  in  1  decoder accepts the head this cycle.
REQ-013 instruction1  out  32  older word of the head pair.
REQ-014 instruction2  out  32  younger word of the head pair.
REQ-015 pair_pc  out  32  address of instruction1.
REQ-016 done  out  1  end of program reached, queue drained.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start=1.
REQ-018 In FETCH, imem_req=1 only when count + inflight < QDEPTH; imem_addr=pc; pc SHALL advance by 8 per request.
REQ-019 Response cycle: a non-squashed imem_rdata SHALL be pushed with its pc; at most one in flight.
REQ-020 valid = queue non-empty; head pops when valid && ready; outputs SHALL show head combinationally from queue storage.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged, including at count=QDEPTH-1 and with one in flight.
REQ-022 Credit rule SHALL make overflow impossible; pop on empty SHALL be impossible because valid=0.
REQ-023 redirect SHALL take priority over push, pop and start: queue emptied, in-flight response squashed, pc<=redirect_pc, state<=FETCH from any state except IDLE; first new request the following cycle.
REQ-024 valid SHALL be 0 in the cycle after redirect.
REQ-025 Pointers SHALL wrap modulo QDEPTH; queue order SHALL be strictly FIFO.
REQ-026 DRAIN: no requests; when count=0 -> DONE; DONE holds done=1 until redirect or reset.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, pc=RESET_PC, count=0, pointers=0, inflight=0, imem_req=0, imem_addr=0, valid=0, instruction1=0, instruction2=0, pair_pc=0, done=0.
REQ-028 Reset mid-operation SHALL discard queue contents and any pending response.

Configuration
REQ-029 Macro FETCH_END_DETECT_EN defined: a pushed pair containing a 32'h0000_0000 word SHALL have each zero word replaced by 32'h0000_0013 (NOP), SHALL still be pushed, and SHALL move FETCH->DRAIN, squashing any later response.
REQ-030 Macro undefined: zero words SHALL pass unmodified, DRAIN/DONE SHALL be unreachable, done SHALL be tied 0.

Verification
REQ-031 Reset, start=1, ready=1, memory of 8 known words at 0x0 -> pairs at pair_pc 0x0,0x8,0x10,0x18 in order with matching words, one per cycle after a 2-cycle startup.
REQ-032 ready=0 for 10 cycles -> exactly QDEPTH=4 pairs buffered, imem_req=0 once credit exhausted; ready=1 -> 4 pairs drain in order, no loss or duplicate.
REQ-033 Redirect to 0x40 while queue holds 3 pairs and one in flight -> next cycle valid=0, then first pair_pc=0x40; no old pair emerges.
REQ-034 With FETCH_END_DETECT_EN, word at 0x14 = 0 -> pair 0x10 delivered with instruction2=32'h0000_0013, no request beyond 0x18, done=1 after queue empties.
REQ-035 reset pulsed low mid-stream with 2 pairs queued -> all outputs 0 asynchronously; after start, fetch restarts at RESET_PC.
REQ-036 Simultaneous push and pop at count=3 for 20 cycles with ready toggling -> count never exceeds 4, pair sequence contiguous.

Source files
------------

// File: rtl/fetch_pair_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pair_unit
// Brief    : Fetches 8-byte instruction pairs into a small FIFO for a decoder.
//            Optional macro FETCH_END_DETECT_EN enables end-of-program detection.
// Revision : 1.0
// ============================================================================
module fetch_pair_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [63:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] instruction1,
    output logic [31:0] instruction2,
    output logic [31:0] pair_pc,
    output logic        done
);

    localparam int              c_PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [c_PW:0]   c_DEPTH   = QDEPTH[c_PW:0];
    localparam logic [c_PW:0]   c_CNT_ONE = 1;
    localparam logic [c_PW-1:0] c_PTR_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_inflight_pc;
    logic            r_inflight;
    logic [c_PW:0]   r_count;
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [31:0]     r_q_i1 [QDEPTH];
    logic [31:0]     r_q_i2 [QDEPTH];
    logic [31:0]     r_q_pc [QDEPTH];

    logic [c_PW+1:0] w_credit;
    logic            w_req;
    logic            w_push;
    logic            w_pop;
    logic            w_end;
    logic [31:0]     w_word1;
    logic [31:0]     w_word2;
    logic            w_unused_rpc;

    assign w_unused_rpc = ^redirect_pc[2:0];

    // Credit counts both stored pairs and the response still on its way back.
    assign w_credit  = {1'b0, r_count} + {{(c_PW+1){1'b0}}, r_inflight};
    assign w_req     = (r_state == S_FETCH) && !redirect && (w_credit < {1'b0, c_DEPTH});
    assign imem_req  = w_req;
    assign imem_addr = w_req ? r_pc : 32'h0;

    assign w_push = r_inflight && !redirect;
    assign valid  = (r_count != '0);
    assign w_pop  = valid && ready && !redirect;

`ifdef FETCH_END_DETECT_EN
    localparam logic [31:0] c_NOP = 32'h0000_0013;
    assign w_end   = (imem_rdata[31:0] == 32'h0) || (imem_rdata[63:32] == 32'h0);
    assign w_word1 = (imem_rdata[31:0]  == 32'h0) ? c_NOP : imem_rdata[31:0];
    assign w_word2 = (imem_rdata[63:32] == 32'h0) ? c_NOP : imem_rdata[63:32];
    assign done    = (r_state == S_DONE);
`else
    assign w_end   = 1'b0;
    assign w_word1 = imem_rdata[31:0];
    assign w_word2 = imem_rdata[63:32];
    assign done    = 1'b0;
`endif

    // Head is gated by valid so a reset or flushed queue shows all zeros.
    assign instruction1 = valid ? r_q_i1[r_rptr] : 32'h0;
    assign instruction2 = valid ? r_q_i2[r_rptr] : 32'h0;
    assign pair_pc      = valid ? r_q_pc[r_rptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_i1[r_wptr] <= w_word1;
            r_q_i2[r_wptr] <= w_word2;
            r_q_pc[r_wptr] <= r_inflight_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= {RESET_PC[31:3], 3'b000};
            r_inflight_pc <= 32'h0;
            r_inflight    <= 1'b0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else if (redirect) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_pc       <= {redirect_pc[31:3], 3'b000};
            if (r_state != S_IDLE) begin
                r_state <= S_FETCH;
            end
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_pc          <= r_pc + 32'd8;
                r_inflight_pc <= r_pc;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Anything requested after the terminating pair is squashed.
                    if (w_push && w_end) begin
                        r_state    <= S_DRAIN;
                        r_inflight <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pair_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pair_unit
// Brief    : Self-checking bench for fetch_pair_unit (stream-level reference).
// Revision : 1.0
// ============================================================================
module tb_fetch_pair_unit;

    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [63:0] imem_rdata = 64'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] instruction1;
    logic [31:0] instruction2;
    logic [31:0] pair_pc;
    logic        done;

    fetch_pair_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .valid(valid), .ready(ready),
        .instruction1(instruction1), .instruction2(instruction2),
        .pair_pc(pair_pc), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit zero14 = 1'b0;

    // Reference stream state: next pair the decoder should see, next address
    // memory should be asked for, and pairs requested but not yet consumed.
    logic [31:0] m_pop_pc;
    logic [31:0] m_req_pc;
    int          m_out;
    bit          m_chk_inv;
    int          pops;
    logic [31:0] max_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (zero14 && a == 32'h14) return 32'h0;
        return 32'hA500_0000 | (a ^ 32'h0003_0000);
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
`ifdef FETCH_END_DETECT_EN
        if (w == 32'h0) w = 32'h0000_0013;
`endif
        return w;
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {mem_word(imem_addr + 32'd4), mem_word(imem_addr)};
        else          imem_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input bit r, input bit rd, input logic [31:0] rp);
        @(posedge clk);
        #1;
        start = s; ready = r; redirect = rd; redirect_pc = rp;
        @(negedge clk);
        if (m_chk_inv) begin
            chk("valid_after_redirect", {31'h0, valid}, 32'h0);
            m_chk_inv = 1'b0;
        end
        if (rd) begin
            m_pop_pc  = rp & ~32'h7;
            m_req_pc  = rp & ~32'h7;
            m_out     = 0;
            m_chk_inv = 1'b1;
        end else begin
            if (valid && r) begin
                chk("pop_pc", pair_pc, m_pop_pc);
                chk("pop_i1", instruction1, exp_word(m_pop_pc));
                chk("pop_i2", instruction2, exp_word(m_pop_pc + 32'd4));
                m_pop_pc += 32'd8;
                m_out--;
                pops++;
            end
            if (imem_req) begin
                chk("req_addr", imem_addr, m_req_pc);
                if (imem_addr > max_req) max_req = imem_addr;
                m_req_pc += 32'd8;
                m_out++;
                chk("credit", {31'h0, (m_out <= QD)}, 32'h1);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; ready = 1'b0; redirect = 1'b0;
        m_pop_pc = RPC; m_req_pc = RPC; m_out = 0; m_chk_inv = 1'b0; max_req = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    typedef struct {
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int p0;
        bit hit;

        vecs[0] = '{1'b0, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 32'h00, 1'b1, 32'h00};
        vecs[2] = '{1'b0, 32'h00, 1'b1, 32'h08};
        vecs[3] = '{1'b1, 32'h00, 1'b1, 32'h10};
        vecs[4] = '{1'b1, 32'h08, 1'b1, 32'h18};
        vecs[5] = '{1'b1, 32'h10, 1'b1, 32'h20};
        vecs[6] = '{1'b1, 32'h18, 1'b1, 32'h28};
        pops = 0;

        // Streaming startup with ready held high.
        do_reset();
        chk("reset_valid", {31'h0, valid}, 32'h0);
        chk("reset_req", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].e_valid});
            chk($sformatf("tbl%0d_pc", i), pair_pc, vecs[i].e_pc);
            chk($sformatf("tbl%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].e_req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
        end

        // Decoder stall fills the queue exactly to depth, then drains in order.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("stall_req", {31'h0, imem_req}, 32'h0);
        chk("stall_valid", {31'h0, valid}, 32'h1);
        chk("stall_outstanding", m_out, QD);
        for (int i = 0; i < QD; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0);
            chk("drain_valid", {31'h0, valid}, 32'h1);
        end

        // Redirect with three pairs queued and one response in flight.
        do_reset();
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            if (imem_req && imem_addr == 32'h18) hit = 1'b1;
        end
        chk("redirect_setup_timeout", {31'h0, hit}, 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0045);
        chk("redirect_cycle_valid", {31'h0, valid}, 32'h1);
        p0 = pops;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redirect_progress", {31'h0, (pops - p0 >= 5)}, 32'h1);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pre_reset_valid", {31'h0, valid}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {31'h0, valid}, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_i1", instruction1, 32'h0);
        chk("arst_i2", instruction2, 32'h0);
        chk("arst_pc", pair_pc, 32'h0);
        chk("arst_done", {31'h0, done}, 32'h0);
        do_reset();
        p0 = pops;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("restart_progress", {31'h0, (pops - p0 >= 4)}, 32'h1);

        // Randomized ready toggling with occasional redirects.
        do_reset();
        p0 = pops;
        for (int i = 0; i < 400; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0),
                $urandom & 32'h0000_0FFF);
        end
        chk("random_progress", {31'h0, (pops - p0 > 50)}, 32'h1);
`ifndef FETCH_END_DETECT_EN
        chk("done_tied_low", {31'h0, done}, 32'h0);
`else
        // End-of-program: zero word at 0x14 terminates the stream.
        do_reset();
        zero14 = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
        chk("end_max_req", max_req, 32'h18);
        chk("end_last_pop", m_pop_pc, 32'h18);
        chk("end_done", {31'h0, done}, 32'h1);
        chk("end_valid", {31'h0, valid}, 32'h0);
        zero14 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
